// File: rtl/wb_mailbox_pkg.sv
// rtl/wb_mailbox_pkg.sv - register map, STATUS/IRQ_EN bit positions and address decode
package wb_mailbox_pkg;

   localparam logic [4:0] ADR_DATA   = 5'h00;
   localparam logic [4:0] ADR_STATUS = 5'h04;
   localparam logic [4:0] ADR_IRQ_EN = 5'h08;
   localparam logic [4:0] ADR_THRESH = 5'h0C;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_CNT_LSB = 2;
   localparam int ST_CNT_MSB = 5;
   localparam int ST_OVF     = 6;
   localparam int ST_UDF     = 7;

   localparam int IRQ_NE  = 0;
   localparam int IRQ_LVL = 1;

   typedef enum logic [2:0] {
      REG_DATA,
      REG_STATUS,
      REG_IRQ_EN,
      REG_THRESH,
      REG_NONE
   } reg_sel_e;

   // Byte lanes within a word are not decoded; only the word index matters.
   function automatic reg_sel_e decode_reg(input logic [4:0] adr);
      case ({adr[4:2], 2'b00})
         ADR_DATA:   return REG_DATA;
         ADR_STATUS: return REG_STATUS;
         ADR_IRQ_EN: return REG_IRQ_EN;
         ADR_THRESH: return REG_THRESH;
         default:    return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// rtl/mailbox_fifo.sv - byte FIFO with wrapping pointers, occupancy count and overflow/underflow events
module mailbox_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      head_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  ovf_o,
   output logic                  udf_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = count_q[DEPTH_LOG2];
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A concurrent pop frees the slot, so a full FIFO still takes the push.
   assign do_push = push_i & (~full_o | do_pop);
   assign ovf_o   = push_i & ~do_push;
   assign udf_o   = pop_i & empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/wb_mailbox_slave.sv
// rtl/wb_mailbox_slave.sv - Wishbone classic mailbox: byte FIFO, sticky status, level interrupt
// Define WB_MAILBOX_ERR_EN to answer unmapped addresses with wb_err_o instead of wb_ack_o.
module wb_mailbox_slave
   import wb_mailbox_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [4:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   input  logic        pop_i,
   output logic [7:0]  head_o,
   output logic        empty_o,
   output logic        int_o
);

   logic [7:0]          head;
   logic                fifo_full, fifo_empty, ovf_evt, udf_evt;
   logic [DEPTH_LOG2:0] fifo_count;
   reg_sel_e            reg_sel;
   logic                req, err_resp, acc, wr_en, push, status_wr;
   logic                ack_q, ack_d, err_q, err_d, int_q, int_d;
   logic                ovf_q, ovf_d, udf_q, udf_d;
   logic [31:0]         dat_q, dat_d;
   logic [1:0]          irq_en_q, irq_en_d;
   logic [3:0]          thresh_q, thresh_d;
   logic [7:0]          status, rdata;
   logic                unused_bits;

   assign unused_bits = ^{wb_dat_i[31:8], wb_sel_i[3:1]};

   assign req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
   assign reg_sel = decode_reg(wb_adr_i);
`ifdef WB_MAILBOX_ERR_EN
   assign err_resp = (reg_sel == REG_NONE);
`else
   assign err_resp = 1'b0;
`endif
   assign acc       = req & ~err_resp;
   assign wr_en     = acc & wb_we_i & wb_sel_i[0];
   assign push      = wr_en & (reg_sel == REG_DATA);
   assign status_wr = wr_en & (reg_sel == REG_STATUS);

   mailbox_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (8)
   ) u_fifo (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (push),
      .data_i  (wb_dat_i[7:0]),
      .pop_i   (pop_i),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .ovf_o   (ovf_evt),
      .udf_o   (udf_evt)
   );

   always_comb begin
      status                         = '0;
      status[ST_EMPTY]               = fifo_empty;
      status[ST_FULL]                = fifo_full;
      status[ST_CNT_MSB:ST_CNT_LSB]  = 4'(fifo_count);
      status[ST_OVF]                 = ovf_q;
      status[ST_UDF]                 = udf_q;
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_DATA:   rdata = head;
         REG_STATUS: rdata = status;
         REG_IRQ_EN: rdata = {6'd0, irq_en_q};
         REG_THRESH: rdata = {4'd0, thresh_q};
         default:    rdata = '0;
      endcase
   end

   always_comb begin
      ack_d    = acc;
      err_d    = req & err_resp;
      dat_d    = (acc & ~wb_we_i) ? {24'd0, rdata} : '0;
      irq_en_d = irq_en_q;
      thresh_d = thresh_q;
      if (wr_en && reg_sel == REG_IRQ_EN) irq_en_d = wb_dat_i[1:0];
      if (wr_en && reg_sel == REG_THRESH) thresh_d = wb_dat_i[3:0];
      // A hardware event in the same cycle as a software clear keeps the bit set.
      ovf_d = ovf_evt | (ovf_q & ~(status_wr & wb_dat_i[ST_OVF]));
      udf_d = udf_evt | (udf_q & ~(status_wr & wb_dat_i[ST_UDF]));
      int_d = (irq_en_q[IRQ_NE] & ~fifo_empty)
            | (irq_en_q[IRQ_LVL] & (thresh_q != 4'd0) & (32'(fifo_count) >= 32'(thresh_q)));
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         dat_q    <= '0;
         int_q    <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         irq_en_q <= '0;
         thresh_q <= '0;
      end else begin
         ack_q    <= ack_d;
         err_q    <= err_d;
         dat_q    <= dat_d;
         int_q    <= int_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         irq_en_q <= irq_en_d;
         thresh_q <= thresh_d;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_dat_o = dat_q;
   assign int_o    = int_q;
   assign head_o   = head;
   assign empty_o  = fifo_empty;

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// tb/tb_wb_mailbox_slave.sv - directed vector table, corner sequences and randomized model check for wb_mailbox_slave
module tb_wb_mailbox_slave;

   localparam int DEPTH = 8;
`ifdef WB_MAILBOX_ERR_EN
   localparam bit ERR_MODE = 1'b1;
`else
   localparam bit ERR_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  adr;
   logic [31:0] wdat;
   logic [31:0] rdat;
   logic [3:0]  sel;
   logic        cyc, stb, we;
   logic        ack, err;
   logic        pop;
   logic [7:0]  head;
   logic        empty;
   logic        intr;

   wb_mailbox_slave #(.DEPTH_LOG2(3)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_adr_i (adr),
      .wb_dat_i (wdat),
      .wb_dat_o (rdat),
      .wb_sel_i (sel),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_ack_o (ack),
      .wb_err_o (err),
      .pop_i    (pop),
      .head_o   (head),
      .empty_o  (empty),
      .int_o    (intr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   // One classic transfer; bounded wait so a missing response cannot hang the run.
   task automatic bus(input logic [4:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      input logic p, output logic [31:0] rd, output logic k_ack, output logic k_err,
                      output int lat);
      adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1; pop = p;
      lat = 0; k_ack = 1'b0; k_err = 1'b0; rd = '0;
      while (lat < 4 && !k_ack && !k_err) begin
         @(posedge clk);
         #1;
         lat++;
         pop   = 1'b0;
         k_ack = ack;
         k_err = err;
         rd    = rdat;
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic pulse_pop();
      pop = 1'b1;
      @(posedge clk);
      #1;
      pop = 1'b0;
   endtask

   // Behavioural model: queue of bytes plus sticky flags and IRQ config.
   logic [7:0] mq[$];
   logic       m_ovf, m_udf;
   logic [1:0] m_irq;
   logic [3:0] m_thr;

   function automatic logic [31:0] m_status();
      int n = mq.size();
      return {24'h0, m_udf, m_ovf, 4'(n), (n == DEPTH), (n == 0)};
   endfunction

   function automatic logic m_int();
      int n = mq.size();
      return (m_irq[0] && n > 0) || (m_irq[1] && m_thr != 0 && n >= int'(m_thr));
   endfunction

   task automatic m_push_pop(input logic do_push, input logic [7:0] b, input logic do_pop);
      logic [7:0] dummy;
      if (do_pop && mq.size() == 0) begin
         m_udf = 1'b1;
         if (do_push) mq.push_back(b);
      end else begin
         if (do_pop) dummy = mq.pop_front();
         if (do_push) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(b);
         end
      end
   endtask

   task automatic m_clear();
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_irq = '0; m_thr = '0;
   endtask

   task automatic mcheck(input string tag);
      check({tag, "_head"}, head, (mq.size() != 0) ? mq[0] : 8'h00);
      check({tag, "_empty"}, empty, mq.size() == 0);
      check({tag, "_int"}, intr, m_int());
   endtask

   task automatic mop(input string tag, input logic [4:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic p, output logic [31:0] rd);
      logic [31:0] exp_rd;
      logic        k_ack, k_err, unm;
      int          lat;
      unm    = a[4];
      exp_rd = '0;
      if (!w) begin
         case (a[4:2])
            3'd0:    exp_rd = (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0;
            3'd1:    exp_rd = m_status();
            3'd2:    exp_rd = {30'd0, m_irq};
            3'd3:    exp_rd = {28'd0, m_thr};
            default: exp_rd = '0;
         endcase
      end
      bus(a, w, d, s, p, rd, k_ack, k_err, lat);
      check({tag, "_ack"}, k_ack, !(ERR_MODE && unm));
      check({tag, "_err"}, k_err, ERR_MODE && unm);
      check({tag, "_lat"}, lat, 1);
      if (!w) check({tag, "_rdata"}, rd, exp_rd);
      if (w && s[0] && !unm) begin
         case (a[3:2])
            2'd1: begin
               if (d[6]) m_ovf = 1'b0;
               if (d[7]) m_udf = 1'b0;
            end
            2'd2: m_irq = d[1:0];
            2'd3: m_thr = d[3:0];
            default: ;
         endcase
      end
      m_push_pop(w && s[0] && a[4:2] == 3'd0, d[7:0], p);
      idle();
      mcheck(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; pop = 1'b0;
      idle();
      idle();
      rst = 1'b0;
      m_clear();
   endtask

   typedef struct {
      bit          is_pop;
      logic [4:0]  a;
      logic        w;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] exp_rd;
      logic        exp_int;
      logic [7:0]  exp_head;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t bv(logic [4:0] a, logic w, logic [31:0] d, logic [3:0] s,
                               logic [31:0] e, logic i, logic [7:0] h);
      vec_t v;
      v.is_pop = 1'b0; v.a = a; v.w = w; v.d = d; v.s = s;
      v.exp_rd = e; v.exp_int = i; v.exp_head = h;
      return v;
   endfunction

   function automatic vec_t pv(logic i, logic [7:0] h);
      vec_t v;
      v = bv(5'h0, 1'b0, 32'h0, 4'h0, 32'h0, i, h);
      v.is_pop = 1'b1;
      return v;
   endfunction

   initial begin
      logic [31:0] rd;
      logic        k_ack, k_err;
      int          lat;
      int          r;
      logic [4:0]  a;
      logic [3:0]  s;
      logic        p;

      adr = '0; wdat = '0; sel = '0; pop = 1'b0;
      do_reset();
      check("rst_ack", ack, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_dat", rdat, 32'h0);
      check("rst_int", intr, 1'b0);
      check("rst_empty", empty, 1'b1);
      check("rst_head", head, 8'h00);

      tbl.push_back(bv(5'h00, 1, 32'hA5,       4'hF, 32'h00, 0, 8'hA5));
      tbl.push_back(bv(5'h00, 1, 32'h3C,       4'hF, 32'h00, 0, 8'hA5));
      tbl.push_back(bv(5'h04, 0, 32'h0,        4'hF, 32'h08, 0, 8'hA5));
      tbl.push_back(bv(5'h00, 0, 32'h0,        4'hF, 32'hA5, 0, 8'hA5));
      tbl.push_back(pv(0, 8'h3C));
      tbl.push_back(bv(5'h00, 0, 32'h0,        4'hF, 32'h3C, 0, 8'h3C));
      tbl.push_back(bv(5'h14, 0, 32'h0,        4'hF, 32'h00, 0, 8'h3C));
      tbl.push_back(bv(5'h1C, 1, 32'hFF,       4'hF, 32'h00, 0, 8'h3C));
      tbl.push_back(bv(5'h00, 1, 32'h77,       4'hE, 32'h00, 0, 8'h3C));
      tbl.push_back(bv(5'h04, 0, 32'h0,        4'hF, 32'h04, 0, 8'h3C));
      tbl.push_back(bv(5'h08, 1, 32'h2,        4'hF, 32'h00, 0, 8'h3C));
      tbl.push_back(bv(5'h0C, 1, 32'hABCDEFF3, 4'hF, 32'h00, 0, 8'h3C));
      tbl.push_back(bv(5'h08, 0, 32'h0,        4'hF, 32'h02, 0, 8'h3C));
      tbl.push_back(bv(5'h0C, 0, 32'h0,        4'hF, 32'h03, 0, 8'h3C));
      tbl.push_back(bv(5'h00, 1, 32'h11,       4'hF, 32'h00, 0, 8'h3C));
      tbl.push_back(bv(5'h00, 1, 32'h22,       4'hF, 32'h00, 1, 8'h3C));
      tbl.push_back(bv(5'h04, 0, 32'h0,        4'hF, 32'h0C, 1, 8'h3C));
      tbl.push_back(pv(0, 8'h11));
      tbl.push_back(pv(0, 8'h22));
      tbl.push_back(pv(0, 8'h00));
      tbl.push_back(pv(0, 8'h00));
      tbl.push_back(bv(5'h04, 0, 32'h0,        4'hF, 32'h81, 0, 8'h00));
      tbl.push_back(bv(5'h04, 1, 32'h80,       4'hF, 32'h00, 0, 8'h00));
      tbl.push_back(bv(5'h04, 0, 32'h0,        4'hF, 32'h01, 0, 8'h00));
      tbl.push_back(bv(5'h08, 1, 32'h1,        4'hF, 32'h00, 0, 8'h00));
      tbl.push_back(bv(5'h00, 1, 32'h5A,       4'hF, 32'h00, 1, 8'h5A));
      tbl.push_back(bv(5'h00, 0, 32'h0,        4'hF, 32'h5A, 1, 8'h5A));
      tbl.push_back(pv(0, 8'h00));
      tbl.push_back(bv(5'h08, 1, 32'h0,        4'hF, 32'h00, 0, 8'h00));
      tbl.push_back(bv(5'h0C, 1, 32'h0,        4'hF, 32'h00, 0, 8'h00));

      foreach (tbl[i]) begin
         if (tbl[i].is_pop) begin
            pulse_pop();
         end else begin
            bus(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, 1'b0, rd, k_ack, k_err, lat);
            check($sformatf("vec%0d_ack", i), k_ack, !(ERR_MODE && tbl[i].a[4]));
            check($sformatf("vec%0d_err", i), k_err, ERR_MODE && tbl[i].a[4]);
            check($sformatf("vec%0d_lat", i), lat, 1);
            if (!tbl[i].w) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         end
         idle();
         check($sformatf("vec%0d_int", i), intr, tbl[i].exp_int);
         check($sformatf("vec%0d_head", i), head, tbl[i].exp_head);
         check($sformatf("vec%0d_dat_idle", i), rdat, 32'h0);
      end

      // Overflow on the ninth push, then software clear of OVF.
      do_reset();
      for (int i = 0; i < 9; i++) mop("fill", 5'h00, 1'b1, 32'h30 + i, 4'hF, 1'b0, rd);
      mop("st_full", 5'h04, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("status_full_ovf", rd, 32'h62);
      mop("ovf_clr", 5'h04, 1'b1, 32'h40, 4'hF, 1'b0, rd);
      mop("st_clr", 5'h04, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("status_ovf_cleared", rd, 32'h22);

      // Push coincident with pop while full: no overflow, new byte lands at the tail.
      mop("full_pp", 5'h00, 1'b1, 32'hEE, 4'hF, 1'b1, rd);
      mop("st_pp", 5'h04, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("status_full_pushpop", rd, 32'h22);
      for (int i = 0; i < 7; i++) begin
         pulse_pop();
         m_push_pop(1'b0, 8'h00, 1'b1);
      end
      idle();
      check("tail_byte", head, 8'hEE);
      mcheck("drain");

      // Underflow set in the same cycle as its software clear: set wins.
      pulse_pop();
      m_push_pop(1'b0, 8'h00, 1'b1);
      mop("udf_race", 5'h04, 1'b1, 32'h80, 4'hF, 1'b1, rd);
      mop("st_race", 5'h04, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("udf_set_wins", rd, 32'h81);

      // Push coincident with pop while empty: byte stored, UDF set.
      mop("udf_clr", 5'h04, 1'b1, 32'hC0, 4'hF, 1'b0, rd);
      mop("empty_pp", 5'h00, 1'b1, 32'h5C, 4'hF, 1'b1, rd);
      mop("st_epp", 5'h04, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("status_empty_pushpop", rd, 32'h84);

      // Reset asserted during a DATA write strobe.
      mop("pre_irq", 5'h08, 1'b1, 32'h3, 4'hF, 1'b0, rd);
      mop("pre_thr", 5'h0C, 1'b1, 32'h1, 4'hF, 1'b0, rd);
      adr = 5'h00; wdat = 32'h99; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_ack", ack, 1'b0);
      check("rst_mid_err", err, 1'b0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
      m_clear();
      idle();
      check("rst_mid_empty", empty, 1'b1);
      check("rst_mid_head", head, 8'h00);
      check("rst_mid_int", intr, 1'b0);
      check("rst_mid_dat", rdat, 32'h0);
      mop("post_st", 5'h04, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("rst_mid_status", rd, 32'h01);
      mop("post_irq", 5'h08, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("rst_mid_irq_en", rd, 32'h0);
      mop("post_thr", 5'h0C, 1'b0, 32'h0, 4'hF, 1'b0, rd);
      check("rst_mid_thresh", rd, 32'h0);

      // Randomized operations against the model.
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 11);
         p = ($urandom_range(0, 3) == 0);
         s = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         case (r)
            0, 1, 2, 3: mop("rnd_push", 5'h00, 1'b1, $urandom, s, p, rd);
            4:  mop("rnd_rdata", 5'h00, 1'b0, 32'h0, 4'hF, p, rd);
            5:  mop("rnd_rstat", 5'h04, 1'b0, 32'h0, 4'hF, p, rd);
            6:  mop("rnd_wstat", 5'h04, 1'b1, $urandom, s, p, rd);
            7:  mop("rnd_irq", 5'h08, 1'b1, 32'($urandom_range(0, 3)), s, p, rd);
            8:  mop("rnd_thr", 5'h0C, 1'b1, 32'($urandom_range(0, 9)), s, p, rd);
            9: begin
               a = {3'($urandom_range(0, 7)), 2'b00};
               mop("rnd_any", a, 1'($urandom_range(0, 1)), $urandom, s, p, rd);
            end
            default: begin
               pulse_pop();
               m_push_pop(1'b0, 8'h00, 1'b1);
               idle();
               mcheck("rnd_pop");
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
